spi_mem_arbiter: RTL and testbench

Shares the single SPI bus (spi_clk/spi_mosi/spi_miso plus separate flash and RAM chip-selects) between the CPU instruction-fetch port and the CPU data port. Arbitrates between the two, then runs one complete single-byte SPI read or write transaction in SPI mode 0. Sits inside soc between the CPU core and the SPI pins.

---
 rtl/spi_mem_pkg.sv | 24 ++
 rtl/spi_bit_engine.sv | 70 +++++++
 rtl/spi_mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_spi_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory arbiter.
// Optional build macro used by this slice: SPI_ARB_RR_EN (round-robin arbitration).
package spi_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    // Bits in one frame: command byte + address bytes + one data byte.
    function automatic int frame_bits(input int addr_bytes);
        return 32'sd16 + 32'sd8 * addr_bytes;
    endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// Mode-0 SPI shifter: two clk cycles per bit (low phase drives mosi,
// high phase samples miso at its end). Signals the final capture edge with
// a done strobe and exposes the byte as it will look after that capture.
module spi_bit_engine #(
    parameter int FRAME_W = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    input  logic               spi_miso,
    output logic               spi_clk,
    output logic               spi_mosi,
    output logic               done,
    output logic [7:0]         rx_next
);

    localparam int CNT_W = $clog2(FRAME_W);

    logic [FRAME_W-1:0] shreg_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               active_r;
    logic               phase_r;
    logic [7:0]         rx_r;
    logic               spi_clk_r;
    logic               mosi_r;

    assign spi_clk  = spi_clk_r;
    assign spi_mosi = mosi_r;
    assign done     = active_r & phase_r & (cnt_r == '0);
    assign rx_next  = {rx_r[6:0], spi_miso};

    // Frame shifting, SPI clock generation and miso capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_r   <= '0;
            cnt_r     <= '0;
            active_r  <= 1'b0;
            phase_r   <= 1'b0;
            rx_r      <= 8'h00;
            spi_clk_r <= 1'b0;
            mosi_r    <= 1'b0;
        end else if (start) begin
            shreg_r   <= frame;
            cnt_r     <= CNT_W'(FRAME_W - 1);
            active_r  <= 1'b1;
            phase_r   <= 1'b0;
            spi_clk_r <= 1'b0;
            mosi_r    <= frame[FRAME_W-1];
        end else if (active_r) begin
            if (!phase_r) begin
                phase_r   <= 1'b1;
                spi_clk_r <= 1'b1;
            end else begin
                rx_r      <= rx_next;
                phase_r   <= 1'b0;
                spi_clk_r <= 1'b0;
                if (cnt_r == '0) begin
                    active_r <= 1'b0;
                    mosi_r   <= 1'b0;
                end else begin
                    cnt_r   <= cnt_r - CNT_W'(1);
                    shreg_r <= {shreg_r[FRAME_W-2:0], 1'b0};
                    mosi_r  <= shreg_r[FRAME_W-2];
                end
            end
        end
    end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one SPI bus and runs a
// single-byte read/write frame on the flash or RAM chip-select.
// Build macro: SPI_ARB_RR_EN selects round-robin arbitration; without it
// the data port always wins a simultaneous request.
module spi_mem_arbiter
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int SPI_ADDR_BYTES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [7:0]        if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [7:0]        d_wdata,
    output logic [7:0]        d_rdata,
    output logic              d_ack,
    output logic              busy,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_flash_ce_n,
    output logic              spi_ram_ce_n
);

    localparam int SPI_ADDR_W = 32'sd8 * SPI_ADDR_BYTES;
    localparam int FRAME_W    = frame_bits(SPI_ADDR_BYTES);

    state_t             state_r, state_next_s;
    grant_t             grant_r, grant_next_s, gnt_s;
    logic               dev_r, dev_next_s;       // 1 = RAM, 0 = flash
    logic               we_r, we_next_s;
    logic               if_ack_r, if_ack_next_s;
    logic               d_ack_r, d_ack_next_s;
    logic [7:0]         if_rdata_r, if_rdata_next_s;
    logic [7:0]         d_rdata_r, d_rdata_next_s;
    logic               busy_r;
    logic               flash_ce_n_r, ram_ce_n_r;
    logic               accept_s;
    logic               start_s;
    logic [FRAME_W-1:0] frame_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic               sel_we_s;
    logic [7:0]         sel_wdata_s;
    logic               eng_done_s;
    logic [7:0]         eng_rx_s;

`ifdef SPI_ARB_RR_EN
    grant_t             ptr_r;
`endif

    assign accept_s       = (state_r == IDLE) && (if_req || d_req);
    assign if_ack         = if_ack_r;
    assign d_ack          = d_ack_r;
    assign if_rdata       = if_rdata_r;
    assign d_rdata        = d_rdata_r;
    assign busy           = busy_r;
    assign spi_flash_ce_n = flash_ce_n_r;
    assign spi_ram_ce_n   = ram_ce_n_r;

    // Pick the port that would win if this were the accept cycle.
    always_comb begin
        gnt_s = GNT_FETCH;
        if (d_req && if_req) begin
`ifdef SPI_ARB_RR_EN
            gnt_s = (ptr_r == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
`else
            gnt_s = GNT_DATA;
`endif
        end else if (d_req) begin
            gnt_s = GNT_DATA;
        end else begin
            gnt_s = GNT_FETCH;
        end
    end

    // Route the winning port's command fields; fetches are always reads.
    always_comb begin
        sel_addr_s  = if_addr;
        sel_we_s    = 1'b0;
        sel_wdata_s = 8'h00;
        if (gnt_s == GNT_DATA) begin
            sel_addr_s  = d_addr;
            sel_we_s    = d_we;
            sel_wdata_s = d_wdata;
        end else begin
            sel_addr_s  = if_addr;
            sel_we_s    = 1'b0;
            sel_wdata_s = 8'h00;
        end
    end

    // Next-state, latch and response logic for the transaction FSM.
    always_comb begin
        state_next_s    = state_r;
        grant_next_s    = grant_r;
        dev_next_s      = dev_r;
        we_next_s       = we_r;
        if_ack_next_s   = 1'b0;
        d_ack_next_s    = 1'b0;
        if_rdata_next_s = if_rdata_r;
        d_rdata_next_s  = d_rdata_r;
        start_s         = 1'b0;
        frame_s         = '0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    grant_next_s = gnt_s;
                    dev_next_s   = sel_addr_s[ADDR_W-1];
                    we_next_s    = sel_we_s;
                    if (sel_we_s && !sel_addr_s[ADDR_W-1]) begin
                        // Flash is read-only here: complete without bus activity.
                        state_next_s = DONE;
                        d_ack_next_s = 1'b1;
                    end else begin
                        state_next_s = SHIFT;
                        start_s      = 1'b1;
                        frame_s      = {(sel_we_s ? CMD_WRITE : CMD_READ),
                                        SPI_ADDR_W'(sel_addr_s),
                                        (sel_we_s ? sel_wdata_s : 8'h00)};
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (eng_done_s) begin
                    state_next_s = DONE;
                    if (grant_r == GNT_DATA) begin
                        d_ack_next_s = 1'b1;
                        if (!we_r) begin
                            d_rdata_next_s = eng_rx_s;
                        end else begin
                            d_rdata_next_s = d_rdata_r;
                        end
                    end else begin
                        if_ack_next_s   = 1'b1;
                        if_rdata_next_s = eng_rx_s;
                    end
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, latched command and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            grant_r      <= GNT_FETCH;
            dev_r        <= 1'b0;
            we_r         <= 1'b0;
            if_ack_r     <= 1'b0;
            d_ack_r      <= 1'b0;
            if_rdata_r   <= 8'h00;
            d_rdata_r    <= 8'h00;
            busy_r       <= 1'b0;
            flash_ce_n_r <= 1'b1;
            ram_ce_n_r   <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            grant_r      <= grant_next_s;
            dev_r        <= dev_next_s;
            we_r         <= we_next_s;
            if_ack_r     <= if_ack_next_s;
            d_ack_r      <= d_ack_next_s;
            if_rdata_r   <= if_rdata_next_s;
            d_rdata_r    <= d_rdata_next_s;
            busy_r       <= (state_next_s != IDLE);
            flash_ce_n_r <= !((state_next_s == SHIFT) && !dev_next_s);
            ram_ce_n_r   <= !((state_next_s == SHIFT) && dev_next_s);
        end
    end

`ifdef SPI_ARB_RR_EN
    // Remember the last granted port so contention alternates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= GNT_FETCH;
        end else if (accept_s) begin
            ptr_r <= gnt_s;
        end
    end
`endif

    spi_bit_engine #(
        .FRAME_W (FRAME_W)
    ) u_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_s),
        .frame    (frame_s),
        .spi_miso (spi_miso),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .done     (eng_done_s),
        .rx_next  (eng_rx_s)
    );

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Scoreboard bench for spi_mem_arbiter: stimulus predicts grant order and
// responses from the arbitration rules; a negedge monitor plays the SPI
// slave and checks every ack against the queued expectation.
module tb_spi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic [7:0]  if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [7:0]  d_wdata;
    logic [7:0]  d_rdata;
    logic        d_ack;
    logic        busy;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;
    logic        spi_flash_ce_n;
    logic        spi_ram_ce_n;

    always #5 clk = ~clk;

    spi_mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_rdata       (if_rdata),
        .if_ack         (if_ack),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_ack          (d_ack),
        .busy           (busy),
        .spi_clk        (spi_clk),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .spi_flash_ce_n (spi_flash_ce_n),
        .spi_ram_ce_n   (spi_ram_ce_n)
    );

`ifdef SPI_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit          is_d;
        bit          spi;
        bit          ram;
        logic [39:0] frame;
        logic [7:0]  resp;
        logic [7:0]  rdata;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          nvec = 0;
    int          nmis = 0;
    logic [7:0]  m_if_rdata = 8'h00;
    logic [7:0]  m_d_rdata  = 8'h00;
    bit          m_last_data = 1'b0;

    int          idx = 0;
    int          busy_cnt = 0;
    bit          prev_sclk = 1'b0;
    bit          fl_seen = 1'b0;
    bit          ram_seen = 1'b0;
    logic [39:0] cap = 40'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor and SPI slave model, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
            fl_seen  = 1'b0;
            ram_seen = 1'b0;
            idx      = 0;
        end else begin
            if (busy) busy_cnt++;
            else busy_cnt = 0;
            if (if_ack || d_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", {if_ack, d_ack}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_port", {if_ack, d_ack}, mon_e.is_d ? 64'd1 : 64'd2);
                    check("rdata", mon_e.is_d ? d_rdata : if_rdata, mon_e.rdata);
                    if (mon_e.spi) begin
                        check("latency", busy_cnt, 64'd81);
                        check("frame", cap, mon_e.frame);
                        check("bit_count", idx, 64'd40);
                        check("ce_sel", {fl_seen, ram_seen}, mon_e.ram ? 64'd1 : 64'd2);
                    end else begin
                        check("drop_latency", busy_cnt, 64'd1);
                        check("drop_ce", {fl_seen, ram_seen}, 64'd0);
                    end
                end
                fl_seen  = 1'b0;
                ram_seen = 1'b0;
            end
            if (spi_flash_ce_n && spi_ram_ce_n) begin
                idx = 0;
            end else begin
                if (!spi_flash_ce_n) fl_seen = 1'b1;
                if (!spi_ram_ce_n) ram_seen = 1'b1;
                if (spi_clk && !prev_sclk) begin
                    if (idx < 40) cap[39-idx] = spi_mosi;
                    if (idx >= 32 && idx < 40 && exp_q.size() > 0)
                        spi_miso = exp_q[0].resp[39-idx];
                    else
                        spi_miso = 1'($urandom_range(0, 1));
                    idx++;
                end
            end
        end
        prev_sclk = spi_clk;
    end

    // Hold one port's request until it has collected n acks (bounded wait).
    task automatic port(input bit is_d, input int n);
        int got = 0;
        int cyc = 0;
        if (n > 0) begin
            while (got < n && cyc < 300) begin
                @(negedge clk);
                cyc++;
                if (is_d ? d_ack : if_ack) begin
                    got++;
                    cyc = 0;
                end
            end
            check(is_d ? "d_ack_count" : "if_ack_count", got, n);
            if (is_d) d_req = 1'b0;
            else if_req = 1'b0;
        end
    endtask

    // Predict grant order and responses, then drive both ports together.
    task automatic scenario(input int nf, input int nd, input logic [15:0] fa, input bit dwe,
                            input logic [15:0] da, input logic [7:0] dwd, input logic [8:0] fr);
        int   rf = nf;
        int   rd = nd;
        bit   pick_d;
        bit   first = 1'b1;
        exp_t e;
        while (rf > 0 || rd > 0) begin
            if (rf > 0 && rd > 0) pick_d = RR ? !m_last_data : 1'b1;
            else pick_d = (rd > 0);
            m_last_data = pick_d;
            e.resp = (first && fr[8]) ? fr[7:0] : 8'($urandom);
            first = 1'b0;
            e.is_d = pick_d;
            if (!pick_d) begin
                rf--;
                e.spi   = 1'b1;
                e.ram   = fa[15];
                e.frame = {8'h03, 8'h00, fa, 8'h00};
                m_if_rdata = e.resp;
                e.rdata = m_if_rdata;
            end else begin
                rd--;
                e.spi   = !(dwe && !da[15]);
                e.ram   = da[15];
                e.frame = {(dwe ? 8'h02 : 8'h03), 8'h00, da, (dwe ? dwd : 8'h00)};
                if (!dwe) m_d_rdata = e.resp;
                e.rdata = m_d_rdata;
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        if_addr = fa;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        if_req  = (nf > 0);
        d_req   = (nd > 0);
        fork
            port(1'b0, nf);
            port(1'b1, nd);
        join
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        if_req  = 1'b0;
        if_addr = 16'h0000;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 16'h0000;
        d_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_bus", {spi_clk, spi_mosi, spi_flash_ce_n, spi_ram_ce_n}, 64'h3);
        check("rst_ack_busy", {if_ack, d_ack, busy}, 64'd0);
        check("rst_rdata", {if_rdata, d_rdata}, 64'd0);
        rst_n = 1'b1;

        scenario(0, 1, 16'h0000, 1'b0, 16'h8012, 8'h00, 9'h1A5);
        scenario(1, 0, 16'h0100, 1'b0, 16'h0000, 8'h00, 9'h13C);
        scenario(0, 1, 16'h0000, 1'b1, 16'h8004, 8'h5A, 9'h000);
        scenario(0, 1, 16'h0000, 1'b1, 16'h0004, 8'h77, 9'h000);
        scenario(2, 2, 16'h0040, 1'b0, 16'h8020, 8'h00, 9'h000);

        for (int i = 0; i < 20; i++) begin
            int nf;
            int nd;
            nf = $urandom_range(0, 2);
            nd = $urandom_range(0, 2);
            if (nf == 0 && nd == 0) nf = 1;
            scenario(nf, nd, 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
                     8'($urandom), 9'h000);
        end

        // Reset in the middle of a RAM read: bus released, no ack ever.
        @(negedge clk);
        d_we   = 1'b0;
        d_addr = 16'h8012;
        d_req  = 1'b1;
        @(negedge clk);
        d_req  = 1'b0;
        repeat (39) @(negedge clk);
        check("mid_busy", busy, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_bus", {spi_clk, spi_flash_ce_n, spi_ram_ce_n, busy}, 64'h6);
        check("abort_rdata", {if_rdata, d_rdata, if_ack, d_ack}, 64'd0);
        rst_n = 1'b1;
        m_if_rdata  = 8'h00;
        m_d_rdata   = 8'h00;
        m_last_data = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_idle", {busy, spi_flash_ce_n, spi_ram_ce_n}, 64'h3);

        scenario(1, 1, 16'h8100, 1'b1, 16'h8044, 8'hC3, 9'h000);
        scenario(1, 1, 16'h0200, 1'b0, 16'h0030, 8'h00, 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
